// File: rtl/bellek_erisim_denetleyici.sv
// Data-memory access controller: accepts one decoded load/store, runs it on a
// valid/ready memory bus, aligns and extends load data, stalls the pipeline
// while busy and reports misaligned accesses and bus timeouts.
module bellek_erisim_denetleyici #(
  parameter int ZAMAN_ASIMI = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        istek_gecerli_i,
  input  logic        oku_i,
  input  logic        yaz_i,
  input  logic [31:0] adres_i,
  input  logic [31:0] veri_i,
  input  logic [3:0]  maske_i,
  input  logic [2:0]  yukle_tur_i,
  output logic        istek_hazir_o,
  output logic        durdur_o,
  output logic        tamam_o,
  output logic [31:0] sonuc_veri_o,
  output logic        hata_o,
  output logic        bellek_istek_o,
  output logic [31:0] bellek_adres_o,
  output logic [31:0] bellek_veri_o,
  output logic [3:0]  bellek_maske_o,
  output logic        bellek_yaz_o,
  input  logic        bellek_hazir_i,
  input  logic        bellek_yanit_gecerli_i,
  input  logic [31:0] bellek_veri_i
);
  localparam int SW = $clog2(ZAMAN_ASIMI + 1);
  localparam logic [SW-1:0] SAYAC_SON = SW'(ZAMAN_ASIMI - 1);

  typedef enum logic [1:0] {BOSTA = 2'd0, ISTEK = 2'd1, YANIT = 2'd2} durum_t;

  typedef struct packed {
    logic [31:0] adres;
    logic [31:0] veri;
    logic [3:0]  maske;
    logic [2:0]  tur;
    logic        yaz;
  } istek_t;

  // access size codes
  localparam logic [1:0] BOY_BAYT  = 2'd0;
  localparam logic [1:0] BOY_YARIM = 2'd1;
  localparam logic [1:0] BOY_KELIME = 2'd2;

  durum_t        durum_q, durum_d;
  istek_t        istek_q;
  logic [SW-1:0] sayac_q;
  logic [1:0]    boyut;
  logic          gecerli_op, hizasiz, kabul, hizasiz_hata;
  logic          tamamla, zaman_doldu, sayac_son;
  logic [7:0]    bayt;
  logic [15:0]   yarim;
  logic [31:0]   genis_veri;

  // Access size: loads from funct3 (undefined types act as LW), stores from the byte mask.
  always_comb begin
    boyut = BOY_BAYT;
    if (oku_i) begin
      case (yukle_tur_i[1:0])
        2'b00:   boyut = BOY_BAYT;
        2'b01:   boyut = BOY_YARIM;
        default: boyut = BOY_KELIME;
      endcase
    end else begin
      case (maske_i)
        4'b1111:                   boyut = BOY_KELIME;
        4'b0011, 4'b0110, 4'b1100: boyut = BOY_YARIM;
        default:                   boyut = BOY_BAYT;
      endcase
    end
  end

  assign hizasiz      = ((boyut == BOY_YARIM) & adres_i[0]) |
                        ((boyut == BOY_KELIME) & (|adres_i[1:0]));
  assign gecerli_op   = (durum_q == BOSTA) & istek_gecerli_i & (oku_i | yaz_i);
  assign kabul        = gecerli_op & ~hizasiz;
  assign hizasiz_hata = gecerli_op & hizasiz;
  assign sayac_son    = (sayac_q >= SAYAC_SON);

  // Next state; completion takes priority over the timeout limit in the same cycle.
  always_comb begin
    durum_d     = durum_q;
    tamamla     = 1'b0;
    zaman_doldu = 1'b0;
    case (durum_q)
      BOSTA: begin
        if (kabul) durum_d = ISTEK;
      end
      ISTEK: begin
        if (bellek_hazir_i && istek_q.yaz) begin
          tamamla = 1'b1;
          durum_d = BOSTA;
        end else if (sayac_son) begin
          zaman_doldu = 1'b1;
          durum_d     = BOSTA;
        end else if (bellek_hazir_i) begin
          durum_d = YANIT;
        end
      end
      YANIT: begin
        if (bellek_yanit_gecerli_i) begin
          tamamla = 1'b1;
          durum_d = BOSTA;
        end else if (sayac_son) begin
          zaman_doldu = 1'b1;
          durum_d     = BOSTA;
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  // Load alignment and sign/zero extension of the returned word.
  always_comb begin
    bayt  = bellek_veri_i[7:0];
    yarim = istek_q.adres[1] ? bellek_veri_i[31:16] : bellek_veri_i[15:0];
    case (istek_q.adres[1:0])
      2'd0:    bayt = bellek_veri_i[7:0];
      2'd1:    bayt = bellek_veri_i[15:8];
      2'd2:    bayt = bellek_veri_i[23:16];
      default: bayt = bellek_veri_i[31:24];
    endcase
    case (istek_q.tur)
      3'b000:  genis_veri = {{24{bayt[7]}}, bayt};
      3'b100:  genis_veri = {24'h0, bayt};
      3'b001:  genis_veri = {{16{yarim[15]}}, yarim};
      3'b101:  genis_veri = {16'h0, yarim};
      default: genis_veri = bellek_veri_i;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) durum_q <= BOSTA;
    else        durum_q <= durum_d;
  end

  // Timeout counter: cleared on acceptance, runs through ISTEK and YANIT.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                sayac_q <= '0;
    else if (kabul)            sayac_q <= '0;
    else if (durum_q != BOSTA) sayac_q <= sayac_q + SW'(1);
  end

  // Latch the accepted request; it drives the bus for the whole transaction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      istek_q <= '0;
    end else if (kabul) begin
      istek_q.adres <= adres_i;
      istek_q.veri  <= veri_i;
      istek_q.maske <= maske_i;
      istek_q.tur   <= yukle_tur_i;
      istek_q.yaz   <= yaz_i;
    end
  end

  // Registered completion/error pulses and load result.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tamam_o      <= 1'b0;
      hata_o       <= 1'b0;
      sonuc_veri_o <= '0;
    end else begin
      tamam_o <= tamamla;
      hata_o  <= hizasiz_hata | zaman_doldu;
      if (tamamla && (durum_q == YANIT)) sonuc_veri_o <= genis_veri;
    end
  end

  assign istek_hazir_o  = (durum_q == BOSTA);
  assign durdur_o       = (durum_q != BOSTA) | kabul;
  assign bellek_istek_o = (durum_q == ISTEK);
  assign bellek_adres_o = {istek_q.adres[31:2], 2'b00};
  assign bellek_veri_o  = istek_q.veri;
  assign bellek_maske_o = istek_q.maske;
  assign bellek_yaz_o   = istek_q.yaz;

endmodule

// File: tb/tb_bellek_erisim_denetleyici.sv
// Bench for bellek_erisim_denetleyici: directed cases plus randomized
// transactions checked against a transaction-level model.
module tb_bellek_erisim_denetleyici;
  localparam int LIMIT = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        istek_gecerli_i, oku_i, yaz_i;
  logic [31:0] adres_i, veri_i;
  logic [3:0]  maske_i;
  logic [2:0]  yukle_tur_i;
  logic        istek_hazir_o, durdur_o, tamam_o, hata_o;
  logic [31:0] sonuc_veri_o;
  logic        bellek_istek_o, bellek_yaz_o;
  logic [31:0] bellek_adres_o, bellek_veri_o;
  logic [3:0]  bellek_maske_o;
  logic        bellek_hazir_i, bellek_yanit_gecerli_i;
  logic [31:0] bellek_veri_i;

  always #5 clk_i = ~clk_i;

  bellek_erisim_denetleyici #(.ZAMAN_ASIMI(LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .istek_gecerli_i(istek_gecerli_i), .oku_i(oku_i), .yaz_i(yaz_i),
    .adres_i(adres_i), .veri_i(veri_i), .maske_i(maske_i), .yukle_tur_i(yukle_tur_i),
    .istek_hazir_o(istek_hazir_o), .durdur_o(durdur_o), .tamam_o(tamam_o),
    .sonuc_veri_o(sonuc_veri_o), .hata_o(hata_o),
    .bellek_istek_o(bellek_istek_o), .bellek_adres_o(bellek_adres_o),
    .bellek_veri_o(bellek_veri_o), .bellek_maske_o(bellek_maske_o),
    .bellek_yaz_o(bellek_yaz_o), .bellek_hazir_i(bellek_hazir_i),
    .bellek_yanit_gecerli_i(bellek_yanit_gecerli_i), .bellek_veri_i(bellek_veri_i)
  );

  int          karsilastirma = 0;
  int          uyumsuz = 0;
  logic        tasinan_tamam = 1'b0;  // pulse expected in the next transaction's first cycle
  logic        tasinan_hata  = 1'b0;
  logic [31:0] bek_sonuc = 32'h0;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    karsilastirma++;
    if (gozlenen !== beklenen) begin
      uyumsuz++;
      $display("FAIL %s: gozlenen=%h beklenen=%h t=%0t", etiket, gozlenen, beklenen, $time);
    end
  endtask

  // Bytes touched by an access: loads by funct3 (undefined = word), stores by mask.
  function automatic int erisim_boyu(input logic oku, input logic [3:0] maske, input logic [2:0] tur);
    if (oku) return (tur[1:0] == 2'b00) ? 1 : (tur[1:0] == 2'b01) ? 2 : 4;
    return $countones(maske);
  endfunction

  function automatic logic [31:0] genislet_model(input logic [2:0] tur, input logic [1:0] o,
                                                 input logic [31:0] w);
    logic [31:0] v;
    case (tur)
      3'b000, 3'b100: begin
        v = (w >> (8 * int'(o))) & 32'hFF;
        if (tur == 3'b000 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        v = (w >> (16 * (int'(o) / 2))) & 32'hFFFF;
        if (tur == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic bos_dongu();
    istek_gecerli_i = 1'b0; oku_i = 1'b0; yaz_i = 1'b0;
    bellek_hazir_i = 1'b0; bellek_yanit_gecerli_i = 1'b0; bellek_veri_i = $urandom();
    @(negedge clk_i);
    kontrol("bos_tamam", 32'(tamam_o), 32'(tasinan_tamam));
    kontrol("bos_hata", 32'(hata_o), 32'(tasinan_hata));
    kontrol("bos_durdur", 32'(durdur_o), 32'd0);
    kontrol("bos_hazir", 32'(istek_hazir_o), 32'd1);
    kontrol("bos_sonuc", sonuc_veri_o, bek_sonuc);
    tasinan_tamam = 1'b0; tasinan_hata = 1'b0;
    @(posedge clk_i); #1;
  endtask

  // One transaction: hd = cycles of bellek_hazir_i low in ISTEK, rd = cycles in YANIT
  // before the response. Completion must fall within LIMIT cycles after leaving BOSTA.
  task automatic islem(input logic oku, input logic yaz, input logic [31:0] adr, input logic [31:0] veri,
                       input logic [3:0] maske, input logic [2:0] tur, input logic [31:0] kelime,
                       input int hd, input int rd);
    int boy, bitis, son, istek_son;
    bit hiz, zd, yanit;
    boy       = erisim_boyu(oku, maske, tur);
    hiz       = (int'(adr[1:0]) % boy) != 0;
    bitis     = yaz ? hd + 1 : hd + 2 + rd;
    zd        = bitis > LIMIT;
    son       = hiz ? 0 : (zd ? LIMIT : bitis);
    istek_son = (hd + 1 < son) ? hd + 1 : son;
    for (int c = 0; c <= son; c++) begin
      if (c == 0) begin
        istek_gecerli_i = 1'b1; oku_i = oku; yaz_i = yaz; adres_i = adr;
        veri_i = veri; maske_i = maske; yukle_tur_i = tur;
      end else begin
        istek_gecerli_i = 1'b1; oku_i = 1'($urandom_range(0, 1)); yaz_i = ~oku_i;
        adres_i = $urandom(); veri_i = $urandom();
        maske_i = 4'($urandom()); yukle_tur_i = 3'($urandom());
      end
      yanit = oku && (c == hd + 2 + rd);
      bellek_hazir_i = (c == hd + 1);
      bellek_yanit_gecerli_i = yanit || (c >= 1 && c <= hd && $urandom_range(0, 1) == 1);
      bellek_veri_i = yanit ? kelime : $urandom();
      @(negedge clk_i);
      kontrol("durdur", 32'(durdur_o), 32'(!hiz));
      kontrol("bellek_istek", 32'(bellek_istek_o), 32'(c >= 1 && c <= istek_son));
      kontrol("tamam", 32'(tamam_o), 32'((c == 0) ? tasinan_tamam : 1'b0));
      kontrol("hata", 32'(hata_o), 32'((c == 0) ? tasinan_hata : 1'b0));
      kontrol("sonuc", sonuc_veri_o, bek_sonuc);
      if (c == 0) kontrol("hazir", 32'(istek_hazir_o), 32'd1);
      if (c >= 1 && c <= istek_son) begin
        kontrol("bus_adres", bellek_adres_o, {adr[31:2], 2'b00});
        kontrol("bus_veri", bellek_veri_o, veri);
        kontrol("bus_maske", 32'(bellek_maske_o), 32'(maske));
        kontrol("bus_yaz", 32'(bellek_yaz_o), 32'(yaz));
      end
      @(posedge clk_i); #1;
    end
    tasinan_tamam = !hiz && !zd;
    tasinan_hata  = hiz || zd;
    if (!hiz && !zd && oku) bek_sonuc = genislet_model(tur, adr[1:0], kelime);
  endtask

  // Reset in ISTEK (yanitta=0) or YANIT (yanitta=1); a late response must be ignored.
  task automatic ortada_sifirla(input bit yanitta);
    istek_gecerli_i = 1'b1; oku_i = 1'b1; yaz_i = 1'b0; adres_i = 32'h300;
    yukle_tur_i = 3'b010; maske_i = 4'hF; veri_i = 32'h5555_AAAA;
    bellek_hazir_i = 1'b0; bellek_yanit_gecerli_i = 1'b0;
    @(negedge clk_i);
    kontrol("rst_kabul", 32'(durdur_o), 32'd1);
    @(posedge clk_i); #1;
    istek_gecerli_i = 1'b0; bellek_hazir_i = yanitta;
    @(negedge clk_i);
    kontrol("rst_istek_once", 32'(bellek_istek_o), 32'd1);
    if (yanitta) begin
      @(posedge clk_i); #1;
      bellek_hazir_i = 1'b0;
      @(negedge clk_i);
      kontrol("rst_yanit_durdur", 32'(durdur_o), 32'd1);
    end
    #2 rst_i = 1'b0;
    #1;
    kontrol("rst_bellek_istek", 32'(bellek_istek_o), 32'd0);
    kontrol("rst_adres", bellek_adres_o, 32'd0);
    kontrol("rst_veri", bellek_veri_o, 32'd0);
    kontrol("rst_maske", 32'(bellek_maske_o), 32'd0);
    kontrol("rst_durdur", 32'(durdur_o), 32'd0);
    kontrol("rst_sonuc", sonuc_veri_o, 32'd0);
    kontrol("rst_tamam", 32'(tamam_o), 32'd0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b1;
    bellek_yanit_gecerli_i = 1'b1; bellek_veri_i = 32'h1234_5678;
    @(negedge clk_i);
    kontrol("gec_yanit_durdur", 32'(durdur_o), 32'd0);
    @(posedge clk_i); #1;
    bellek_yanit_gecerli_i = 1'b0;
    @(negedge clk_i);
    kontrol("gec_yanit_tamam", 32'(tamam_o), 32'd0);
    kontrol("gec_yanit_hata", 32'(hata_o), 32'd0);
    kontrol("gec_yanit_sonuc", sonuc_veri_o, 32'd0);
    @(posedge clk_i); #1;
    bek_sonuc = 32'h0; tasinan_tamam = 1'b0; tasinan_hata = 1'b0;
  endtask

  localparam logic [3:0] MASKELER [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  initial begin
    istek_gecerli_i = 1'b0; oku_i = 1'b0; yaz_i = 1'b0; adres_i = '0; veri_i = '0;
    maske_i = '0; yukle_tur_i = '0; bellek_hazir_i = 1'b0; bellek_yanit_gecerli_i = 1'b0;
    bellek_veri_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    kontrol("reset_hazir", 32'(istek_hazir_o), 32'd1);
    kontrol("reset_istek", 32'(bellek_istek_o), 32'd0);
    kontrol("reset_durdur", 32'(durdur_o), 32'd0);
    kontrol("reset_tamam", 32'(tamam_o), 32'd0);
    kontrol("reset_hata", 32'(hata_o), 32'd0);
    kontrol("reset_sonuc", sonuc_veri_o, 32'd0);
    kontrol("reset_adres", bellek_adres_o, 32'd0);
    kontrol("reset_yaz", 32'(bellek_yaz_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    bos_dongu();

    // aligned LW, extensions, delayed-ready SB
    islem(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 3'b010, 32'hDEAD_BEEF, 0, 0); bos_dongu();
    islem(1'b1, 1'b0, 32'h103, 32'h0, 4'h0, 3'b000, 32'h80FF_7F01, 0, 0);
    islem(1'b1, 1'b0, 32'h103, 32'h0, 4'h0, 3'b100, 32'h80FF_7F01, 0, 1);
    islem(1'b1, 1'b0, 32'h102, 32'h0, 4'h0, 3'b001, 32'h80FF_7F01, 1, 0);
    islem(1'b1, 1'b0, 32'h102, 32'h0, 4'h0, 3'b101, 32'h80FF_7F01, 0, 0);
    islem(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 3'b011, 32'hCAFE_F00D, 0, 0);
    islem(1'b0, 1'b1, 32'h201, 32'h0000_AB00, 4'b0010, 3'b000, 32'h0, 3, 0); bos_dongu();
    // misaligned LW and SH
    islem(1'b1, 1'b0, 32'h102, 32'h0, 4'hF, 3'b010, 32'h1111_1111, 0, 0);
    islem(1'b0, 1'b1, 32'h203, 32'hAB00_0000, 4'b1100, 3'b000, 32'h0, 0, 0); bos_dongu();
    // timeout and limit boundaries
    islem(1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 3'b010, 32'h2222_2222, 0, 20);
    islem(1'b1, 1'b0, 32'h404, 32'h0, 4'hF, 3'b010, 32'h3333_3333, 0, 0);
    islem(1'b0, 1'b1, 32'h408, 32'h7777_7777, 4'hF, 3'b010, 32'h0, 7, 0);
    islem(1'b0, 1'b1, 32'h40C, 32'h8888_8888, 4'hF, 3'b010, 32'h0, 8, 0);
    islem(1'b1, 1'b0, 32'h410, 32'h0, 4'hF, 3'b010, 32'h4444_4444, 0, 6);
    islem(1'b1, 1'b0, 32'h414, 32'h0, 4'hF, 3'b010, 32'h5555_5555, 0, 7);
    islem(1'b1, 1'b0, 32'h418, 32'h0, 4'hF, 3'b010, 32'h6666_6666, 6, 0);
    islem(1'b1, 1'b0, 32'h41C, 32'h0, 4'hF, 3'b010, 32'h9999_9999, 7, 0);
    bos_dongu();

    for (int n = 0; n < 250; n++) begin
      logic o;
      int hd, rd;
      o  = 1'($urandom_range(0, 1));
      hd = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 3);
      rd = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 9) : $urandom_range(0, 3);
      islem(o, ~o, $urandom(), $urandom(), MASKELER[$urandom_range(0, 6)], 3'($urandom()),
            $urandom(), hd, rd);
      if ($urandom_range(0, 2) == 0) bos_dongu();
    end
    bos_dongu();

    islem(1'b1, 1'b0, 32'h500, 32'h0, 4'hF, 3'b010, 32'hA5A5_5A5A, 0, 0); bos_dongu();
    ortada_sifirla(1'b0);
    islem(1'b1, 1'b0, 32'h504, 32'h0, 4'hF, 3'b010, 32'h0BAD_CAFE, 0, 0); bos_dongu();
    ortada_sifirla(1'b1);
    islem(1'b0, 1'b1, 32'h508, 32'h1357_9BDF, 4'hF, 3'b010, 32'h0, 0, 0); bos_dongu();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", karsilastirma, uyumsuz);
    $finish;
  end
endmodule
